// File: rtl/nw_align_pkg.sv
// Shared types for the NW aligned-pair buffer: symbol codes, FSM states, pair layout.
// The optional statistics outputs are enabled by defining ALIGN_STATS_EN.
package nw_align_pkg;
    localparam int SYM_W = 3;

    localparam logic [SYM_W-1:0] SYM_A   = 3'd0;
    localparam logic [SYM_W-1:0] SYM_C   = 3'd1;
    localparam logic [SYM_W-1:0] SYM_G   = 3'd2;
    localparam logic [SYM_W-1:0] SYM_T   = 3'd3;
    localparam logic [SYM_W-1:0] GAP_SYM = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_DRAIN,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [SYM_W-1:0] a;
        logic [SYM_W-1:0] b;
    } pair_t;
endpackage

// File: rtl/nw_pair_ram.sv
// Simple dual-port pair storage: synchronous write, registered read with read enable.
// The array itself is never reset; only the read register is.
module nw_pair_ram #(
    parameter int DEPTH = 256,
    parameter int W     = 6,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read register holds its value while re is low, which keeps the output stable on stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata_q <= '0;
        else if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/nw_aligned_pair_buffer.sv
// LIFO replay buffer for traceback pairs: fills in reverse order, drains forward over valid/ready.
// Define ALIGN_STATS_EN to add match/mismatch/gap counters.
module nw_aligned_pair_buffer #(
    parameter int N      = 128,
    parameter int SYM_W  = nw_align_pkg::SYM_W,
    localparam int PTR_W = $clog2(2*N+1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             en_traceB,
    input  logic [SYM_W-1:0] sym_a,
    input  logic [SYM_W-1:0] sym_b,
    input  logic             tb_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SYM_W-1:0] out_a,
    output logic [SYM_W-1:0] out_b,
    output logic             out_last,
    output logic [PTR_W-1:0] align_len,
`ifdef ALIGN_STATS_EN
    output logic [PTR_W-1:0] n_match,
    output logic [PTR_W-1:0] n_mismatch,
    output logic [PTR_W-1:0] n_gap,
`endif
    output logic             overflow,
    output logic             done
);
    import nw_align_pkg::*;

    localparam int DEPTH = 2*N;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

    state_e           state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             rd_left_q, rd_left_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [PTR_W-1:0] align_len_q, align_len_d;
    logic             overflow_q, overflow_d;
    logic             done_q, done_d;
`ifdef ALIGN_STATS_EN
    logic [PTR_W-1:0] n_match_q, n_match_d;
    logic [PTR_W-1:0] n_mismatch_q, n_mismatch_d;
    logic [PTR_W-1:0] n_gap_q, n_gap_d;
`endif

    logic             wr_full, wr_acc, advance, ram_re;
    logic [PTR_W-1:0] cnt;
    logic [2*SYM_W-1:0] rdata;

    always_comb begin
        wr_full = (wr_ptr_q == DEPTH_P);
        wr_acc  = (state_q == ST_FILL) && en_traceB && !wr_full;
        // Pair count including a write landing in this very cycle.
        cnt     = wr_ptr_q + PTR_W'(wr_acc);
        advance = !out_valid_q || out_ready;

        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rd_left_d   = rd_left_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        align_len_d = align_len_q;
        overflow_d  = overflow_q;
        done_d      = 1'b0;
        ram_re      = 1'b0;
`ifdef ALIGN_STATS_EN
        n_match_d    = n_match_q;
        n_mismatch_d = n_mismatch_q;
        n_gap_d      = n_gap_q;
`endif

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_FILL;
                    wr_ptr_d    = '0;
                    overflow_d  = 1'b0;
                    align_len_d = '0;
`ifdef ALIGN_STATS_EN
                    n_match_d    = '0;
                    n_mismatch_d = '0;
                    n_gap_d      = '0;
`endif
                end
            end
            ST_FILL: begin
                if (wr_acc) wr_ptr_d = cnt;
                if (en_traceB && wr_full) overflow_d = 1'b1;
`ifdef ALIGN_STATS_EN
                if (wr_acc) begin
                    if (sym_a == SYM_W'(GAP_SYM) || sym_b == SYM_W'(GAP_SYM)) n_gap_d = n_gap_q + 1'b1;
                    else if (sym_a == sym_b) n_match_d = n_match_q + 1'b1;
                    else                     n_mismatch_d = n_mismatch_q + 1'b1;
                end
`endif
                if (tb_done) begin
                    align_len_d = cnt;
                    if (cnt == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = ST_DRAIN;
                        rd_ptr_d  = AW'(cnt - 1'b1);
                        rd_left_d = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (advance) begin
                    if (rd_left_q) begin
                        ram_re      = 1'b1;
                        out_valid_d = 1'b1;
                        out_last_d  = (rd_ptr_q == '0);
                        if (rd_ptr_q == '0) rd_left_d = 1'b0;
                        else                rd_ptr_d  = rd_ptr_q - 1'b1;
                    end else begin
                        // Nothing left to fetch, so an advance here is the last pair's handshake.
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        if (out_valid_q) begin
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd_left_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            align_len_q <= '0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_left_q   <= rd_left_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            align_len_q <= align_len_d;
            overflow_q  <= overflow_d;
            done_q      <= done_d;
        end
    end

`ifdef ALIGN_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_match_q    <= '0;
            n_mismatch_q <= '0;
            n_gap_q      <= '0;
        end else begin
            n_match_q    <= n_match_d;
            n_mismatch_q <= n_mismatch_d;
            n_gap_q      <= n_gap_d;
        end
    end

    assign n_match    = n_match_q;
    assign n_mismatch = n_mismatch_q;
    assign n_gap      = n_gap_q;
`endif

    nw_pair_ram #(
        .DEPTH (DEPTH),
        .W     (2*SYM_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_acc),
        .waddr (AW'(wr_ptr_q)),
        .wdata ({sym_a, sym_b}),
        .re    (ram_re),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_a     = rdata[2*SYM_W-1:SYM_W];
    assign out_b     = rdata[SYM_W-1:0];
    assign align_len = align_len_q;
    assign overflow  = overflow_q;
    assign done      = done_q;
endmodule

// File: tb/tb_nw_aligned_pair_buffer.sv
// Randomized bench for nw_aligned_pair_buffer (N=4, depth 8) against a queue-based LIFO model.
module tb_nw_aligned_pair_buffer;
    import nw_align_pkg::*;

    localparam int TB_N  = 4;
    localparam int DEPTH = 2*TB_N;
    localparam int PTR_W = $clog2(2*TB_N+1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0, en_traceB = 1'b0, tb_done = 1'b0, out_ready = 1'b0;
    logic [SYM_W-1:0] sym_a = '0, sym_b = '0;
    logic             out_valid, out_last, overflow, done;
    logic [SYM_W-1:0] out_a, out_b;
    logic [PTR_W-1:0] align_len;
`ifdef ALIGN_STATS_EN
    logic [PTR_W-1:0] n_match, n_mismatch, n_gap;
`endif

    int n_chk = 0;
    int n_pass = 0;

    pair_t q[$];
    bit    exp_ovf;
    int    e_match, e_mismatch, e_gap;

    always #5 clk = ~clk;

    nw_aligned_pair_buffer #(.N(TB_N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .en_traceB (en_traceB),
        .sym_a     (sym_a),
        .sym_b     (sym_b),
        .tb_done   (tb_done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_last  (out_last),
        .align_len (align_len),
`ifdef ALIGN_STATS_EN
        .n_match   (n_match),
        .n_mismatch(n_mismatch),
        .n_gap     (n_gap),
`endif
        .overflow  (overflow),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic pair_t pick(input int mode, input int i);
        pair_t p;
        logic [SYM_W-1:0] dir1 [4];
        dir1[0] = SYM_A; dir1[1] = SYM_C; dir1[2] = SYM_G; dir1[3] = SYM_T;
        if (mode == 1) begin
            p.a = dir1[i % 4];
            p.b = dir1[i % 4];
        end else if (mode == 2) begin
            p.a = (i == 0) ? SYM_A : (i == 1) ? SYM_C : SYM_T;
            p.b = (i == 0) ? SYM_A : (i == 1) ? SYM_G : GAP_SYM;
        end else begin
            p.a = SYM_W'($urandom_range(0, 4));
            p.b = ($urandom_range(0, 2) == 0) ? p.a : SYM_W'($urandom_range(0, 4));
        end
        return p;
    endfunction

    // mode: 0 random symbols with idle gaps and stray controls, 1 ACGT with B=A, 2 stats pattern.
    task automatic run_case(input int nwr, input int mode, input bit rnd_ready);
        int    i, cyc, first_cyc, done_cyc, exp_idx, n;
        bit    got_done;
        pair_t p, e;
        q.delete();
        exp_ovf = 0; e_match = 0; e_mismatch = 0; e_gap = 0;

        start = 1'b1; en_traceB = 1'b0; tb_done = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_clr_ovf", overflow, 0);
        chk("start_clr_len", align_len, 0);

        i = 0;
        while (i < nwr) begin
            if (mode == 0 && $urandom_range(0, 3) == 0) begin
                en_traceB = 1'b0; tb_done = 1'b0;
                start = 1'($urandom_range(0, 1));
            end else begin
                p = pick(mode, i);
                en_traceB = 1'b1; sym_a = p.a; sym_b = p.b;
                tb_done = (i == nwr - 1);
                start = (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                if (q.size() < DEPTH) begin
                    q.push_back(p);
                    if (p.a == GAP_SYM || p.b == GAP_SYM) e_gap++;
                    else if (p.a == p.b) e_match++;
                    else e_mismatch++;
                end else exp_ovf = 1;
                i++;
            end
            @(posedge clk); #1;
        end
        if (nwr == 0) begin
            tb_done = 1'b1; en_traceB = 1'b0;
            @(posedge clk); #1;
        end
        en_traceB = 1'b0; tb_done = 1'b0; start = 1'b0;

        n = q.size();
        exp_idx = 0; cyc = 0; first_cyc = -1; done_cyc = -1; got_done = 0;
        while (!got_done && cyc < 200) begin
            if (done) begin
                got_done = 1; done_cyc = cyc;
                start = 1'b0; en_traceB = 1'b0; tb_done = 1'b0;
                chk("done_all_consumed", exp_idx, n);
                chk("done_valid_low", out_valid, 0);
                chk("done_align_len", align_len, n);
                chk("done_overflow", overflow, exp_ovf);
`ifdef ALIGN_STATS_EN
                chk("n_match", n_match, e_match);
                chk("n_mismatch", n_mismatch, e_mismatch);
                chk("n_gap", n_gap, e_gap);
`endif
            end else begin
                if (out_valid) begin
                    if (first_cyc < 0) first_cyc = cyc;
                    if (exp_idx < n) begin
                        e = q[n - 1 - exp_idx];
                        chk("out_a", out_a, e.a);
                        chk("out_b", out_b, e.b);
                        chk("out_last", out_last, (exp_idx == n - 1));
                        chk("drain_align_len", align_len, n);
                    end else chk("extra_pair", exp_idx, n - 1);
                end
                out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (out_valid && out_ready) exp_idx++;
                if (mode == 0) begin
                    start = 1'($urandom_range(0, 1));
                    en_traceB = 1'($urandom_range(0, 1));
                    tb_done = 1'($urandom_range(0, 1));
                    sym_a = SYM_W'($urandom); sym_b = SYM_W'($urandom);
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        if (!got_done) chk("drain_timeout", 0, 1);
        if (n > 0) chk("first_valid_latency", first_cyc, 1);
        if (n > 0 && !rnd_ready && got_done) chk("drain_throughput", done_cyc - first_cyc, n);
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
        chk("idle_valid_low", out_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_len", align_len, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_done", done, 0);
        chk("rst_out_a", out_a, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_case(4, 1, 0);
        run_case(4, 1, 1);
        run_case(9, 0, 0);
        run_case(0, 0, 1);
        run_case(3, 2, 0);

        // Asynchronous reset while pairs are waiting in DRAIN.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            en_traceB = 1'b1; sym_a = SYM_W'(k + 1); sym_b = SYM_W'(k + 1);
            tb_done = (k == 2);
            @(posedge clk); #1;
        end
        en_traceB = 1'b0; tb_done = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_out_a", out_a, 0);
        chk("arst_out_b", out_b, 0);
        chk("arst_last", out_last, 0);
        chk("arst_len", align_len, 0);
        chk("arst_done", done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_case(5, 0, 1);

        for (int t = 0; t < 25; t++) run_case($urandom_range(0, 10), 0, 1'($urandom_range(0, 1)));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
